ahb_master_arbiter: RTL and testbench

AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

---
 rtl/ahb_master_arbiter_pkg.sv | 28 ++
 rtl/ahb_master_arbiter_if.sv | 38 +++
 rtl/ahb_master_arbiter_rr_pick.sv | 40 ++++
 rtl/ahb_master_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/ahb_master_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ahb_master_arbiter_pkg
// Shared definitions for the AHB master arbiter:
//   - Htrans transfer-type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - Arbiter FSM state encodings (PARK/OWNED/LOCKED)
//   - is_beat(): true for transfer types that count as a data beat
// ----------------------------------------------------------------------------
package ahb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_PARK   = 2'b00,
        ST_OWNED  = 2'b01,
        ST_LOCKED = 2'b10
    } arb_state_e;

    // Only NONSEQ and SEQ move data; IDLE and BUSY do not count toward the hold limit.
    function automatic logic is_beat(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_master_arbiter_if
// Bus-side signals of the AHB master arbiter.
//   Hbusreq   [MASTERS]  per-master bus request
//   Hlock     [MASTERS]  per-master locked-transfer request
//   Htrans    [2]        transfer type of the currently muxed master
//   Hready    [1]        bridge Hreadyout, qualifies arbitration
//   Hgrant    [MASTERS]  one-hot grant
//   Hmaster   [IDX_W]    address-phase owner index
//   Hmastlock [1]        address-phase transfer is locked
// Modports:
//   master : requester/bridge side (drives requests, Htrans, Hready)
//   slave  : arbiter side (receives requests, drives grant/owner/lock)
// ----------------------------------------------------------------------------
interface ahb_master_arbiter_if #(
    parameter int MASTERS = 4
);
    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    logic [MASTERS-1:0] Hbusreq;
    logic [MASTERS-1:0] Hlock;
    logic [1:0]         Htrans;
    logic               Hready;
    logic [MASTERS-1:0] Hgrant;
    logic [IDX_W-1:0]   Hmaster;
    logic               Hmastlock;

    modport master (
        output Hbusreq, Hlock, Htrans, Hready,
        input  Hgrant, Hmaster, Hmastlock
    );

    modport slave (
        input  Hbusreq, Hlock, Htrans, Hready,
        output Hgrant, Hmaster, Hmastlock
    );

endinterface

// File: rtl/ahb_master_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
//   req_i        [MASTERS]  request vector
//   last_owner_i [IDX_W]    most recent winner; search starts one above it
//   grant_o      [MASTERS]  one-hot winner (all zero when no request)
//   idx_o        [IDX_W]    index of the winner
//   valid_o      [1]        at least one request present
// MASTERS is a power of two, so the wrap-around is plain IDX_W-bit overflow.
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int MASTERS = 4,
    parameter int IDX_W   = 2
) (
    input  logic [MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // i = MASTERS lands back on last_owner itself, so it is considered last.
        for (int i = 1; i <= MASTERS; i++) begin
            cand = last_owner_i + IDX_W'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_master_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_master_arbiter
// Round-robin AHB bus arbiter with parking, beat-limited ownership and an
// optional locked-transfer mode.
// Parameters:
//   MASTERS  number of requesters (power of two, 2..4)
//   HOLD_MAX beats an owner keeps the bus while another master waits
//   PARK_ID  master granted when nothing is requested
// Ports:
//   Hclk     clock, rising edge
//   Hreset   asynchronous active-high reset
//   bus      ahb_master_arbiter_if.slave (Hbusreq, Hlock, Htrans, Hready in;
//            Hgrant, Hmaster, Hmastlock out)
// Build option:
//   ARB_LOCK_EN  defined: owner with Hlock enters LOCKED and keeps the bus
//                until Hlock drops; Hmastlock reports LOCKED.
//                undefined: Hlock ignored, Hmastlock tied low.
//
// state  | meaning
// PARK   | no request pending, grant parked on PARK_ID
// OWNED  | a master owns the bus, subject to re-arbitration
// LOCKED | owner is performing a locked sequence, no re-arbitration
// ----------------------------------------------------------------------------
module ahb_master_arbiter
    import ahb_master_arbiter_pkg::*;
#(
    parameter int MASTERS  = 4,
    parameter int HOLD_MAX = 16,
    parameter int PARK_ID  = 0
) (
    input  logic                 Hclk,
    input  logic                 Hreset,
    ahb_master_arbiter_if.slave  bus
);

    localparam int IDX_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [IDX_W-1:0]   PARK_IDX   = IDX_W'(PARK_ID);
    localparam logic [MASTERS-1:0] PARK_GRANT = MASTERS'(1) << PARK_ID;
    localparam logic [CNT_W-1:0]   HOLD_CNT   = CNT_W'(HOLD_MAX);

    arb_state_e         state_q, state_d;
    logic [MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [IDX_W-1:0]   hmaster_q, hmaster_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic any_req;
    logic owner_req;
    logic others_req;
    logic hold_expired;
    logic rearb;
    logic lock_now;

    rr_pick #(
        .MASTERS (MASTERS),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i        (bus.Hbusreq),
        .last_owner_i (last_owner_q),
        .grant_o      (pick_grant),
        .idx_o        (pick_idx),
        .valid_o      (pick_valid)
    );

    assign any_req      = |bus.Hbusreq;
    assign owner_req    = bus.Hbusreq[owner_q];
    assign others_req   = |(bus.Hbusreq & ~grant_q);
    assign hold_expired = (beat_cnt_q == HOLD_CNT) && others_req;
    assign rearb        = !owner_req || (bus.Htrans == HTRANS_IDLE) || hold_expired;

`ifdef ARB_LOCK_EN
    assign lock_now = bus.Hlock[owner_q];
`else
    logic unused_hlock;
    assign unused_hlock = ^bus.Hlock;
    assign lock_now     = 1'b0;
`endif

    // State register: everything freezes unless Hready is high, reset is immediate.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q      <= ST_PARK;
            grant_q      <= PARK_GRANT;
            owner_q      <= PARK_IDX;
            last_owner_q <= PARK_IDX;
            hmaster_q    <= PARK_IDX;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hmaster_q    <= hmaster_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hmaster_d    = hmaster_q;
        beat_cnt_d   = beat_cnt_q;

        if (bus.Hready) begin
            // Address phase follows the grant one Hready edge later.
            hmaster_d = owner_q;

            if (is_beat(bus.Htrans) && (beat_cnt_q != HOLD_CNT)) begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end

            unique case (state_q)
                ST_PARK: begin
                    if (pick_valid) begin
                        state_d      = ST_OWNED;
                        grant_d      = pick_grant;
                        owner_d      = pick_idx;
                        last_owner_d = pick_idx;
                        beat_cnt_d   = '0;
                    end
                end

                ST_OWNED: begin
                    if (lock_now) begin
`ifdef ARB_LOCK_EN
                        state_d = ST_LOCKED;
`endif
                    end else if (rearb) begin
                        if (!any_req) begin
                            state_d    = ST_PARK;
                            grant_d    = PARK_GRANT;
                            owner_d    = PARK_IDX;
                            beat_cnt_d = '0;
                        end else if (pick_grant != grant_q) begin
                            grant_d      = pick_grant;
                            owner_d      = pick_idx;
                            last_owner_d = pick_idx;
                            beat_cnt_d   = '0;
                        end
                        // Otherwise only the owner is requesting: keep the grant.
                    end
                end

`ifdef ARB_LOCK_EN
                ST_LOCKED: begin
                    if (!lock_now) begin
                        state_d = ST_OWNED;
                    end
                end
`endif

                default: begin
                    state_d    = ST_PARK;
                    grant_d    = PARK_GRANT;
                    owner_d    = PARK_IDX;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        bus.Hgrant  = grant_q;
        bus.Hmaster = hmaster_q;
`ifdef ARB_LOCK_EN
        bus.Hmastlock = (state_q == ST_LOCKED);
`else
        bus.Hmastlock = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
module tb_ahb_master_arbiter;
    import ahb_master_arbiter_pkg::*;

    logic Hclk;
    logic Hreset;

    ahb_master_arbiter_if #(.MASTERS(4)) bus ();

    ahb_master_arbiter #(
        .MASTERS  (4),
        .HOLD_MAX (16),
        .PARK_ID  (0)
    ) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       ready;
        logic [3:0] req;
        logic [1:0] trans;
        logic [3:0] exp_g;
        logic [1:0] exp_m;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] em,
                         input logic el);
        checks++;
        if (bus.Hgrant !== eg) begin
            errors++;
            $display("FAIL %s Hgrant: got %b want %b", tag, bus.Hgrant, eg);
        end
        checks++;
        if (bus.Hmaster !== em) begin
            errors++;
            $display("FAIL %s Hmaster: got %0d want %0d", tag, bus.Hmaster, em);
        end
        checks++;
        if (bus.Hmastlock !== el) begin
            errors++;
            $display("FAIL %s Hmastlock: got %b want %b", tag, bus.Hmastlock, el);
        end
        checks++;
        if (!$onehot(bus.Hgrant)) begin
            errors++;
            $display("FAIL %s onehot: got %b want exactly one bit", tag, bus.Hgrant);
        end
    endtask

    task automatic drive(input logic rdy, input logic [3:0] req, input logic [1:0] tr,
                         input logic [3:0] lk);
        bus.Hready  = rdy;
        bus.Hbusreq = req;
        bus.Htrans  = tr;
        bus.Hlock   = lk;
    endtask

    task automatic step();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        // ready, req, trans, expected grant, expected Hmaster
        vecs[0]  = '{1'b1, 4'b0000, HTRANS_IDLE,   4'b0001, 2'd0};
        vecs[1]  = '{1'b1, 4'b0110, HTRANS_NONSEQ, 4'b0010, 2'd0};
        vecs[2]  = '{1'b1, 4'b0110, HTRANS_NONSEQ, 4'b0010, 2'd1};
        vecs[3]  = '{1'b1, 4'b0100, HTRANS_NONSEQ, 4'b0100, 2'd1};
        vecs[4]  = '{1'b1, 4'b0100, HTRANS_SEQ,    4'b0100, 2'd2};
        vecs[5]  = '{1'b1, 4'b0000, HTRANS_IDLE,   4'b0001, 2'd2};
        vecs[6]  = '{1'b1, 4'b0010, HTRANS_NONSEQ, 4'b0010, 2'd0};
        vecs[7]  = '{1'b1, 4'b0010, HTRANS_SEQ,    4'b0010, 2'd1};
        vecs[8]  = '{1'b0, 4'b0000, HTRANS_SEQ,    4'b0010, 2'd1};
        vecs[9]  = '{1'b0, 4'b0000, HTRANS_SEQ,    4'b0010, 2'd1};
        vecs[10] = '{1'b0, 4'b0000, HTRANS_SEQ,    4'b0010, 2'd1};
        vecs[11] = '{1'b1, 4'b0000, HTRANS_SEQ,    4'b0001, 2'd1};
        vecs[12] = '{1'b1, 4'b0000, HTRANS_IDLE,   4'b0001, 2'd0};
        vecs[13] = '{1'b1, 4'b1111, HTRANS_NONSEQ, 4'b0100, 2'd0};
        vecs[14] = '{1'b1, 4'b1011, HTRANS_NONSEQ, 4'b1000, 2'd2};
        vecs[15] = '{1'b1, 4'b1011, HTRANS_IDLE,   4'b0001, 2'd3};
        vecs[16] = '{1'b1, 4'b0001, HTRANS_NONSEQ, 4'b0001, 2'd0};
        vecs[17] = '{1'b1, 4'b0001, HTRANS_IDLE,   4'b0001, 2'd0};
        vecs[18] = '{1'b1, 4'b0000, HTRANS_IDLE,   4'b0001, 2'd0};

        Hreset = 1'b1;
        drive(1'b1, 4'b0000, HTRANS_IDLE, 4'b0000);
        repeat (2) @(posedge Hclk);
        #1;
        check("reset_hold", 4'b0001, 2'd0, 1'b0);
        @(negedge Hclk);
        Hreset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ready, vecs[i].req, vecs[i].trans, 4'b0000);
            step();
            check($sformatf("vec%0d", i), vecs[i].exp_g, vecs[i].exp_m, 1'b0);
        end

        // Hold limit: master 2 streams SEQ beats while master 3 waits.
        drive(1'b1, 4'b0100, HTRANS_NONSEQ, 4'b0000);
        step();
        check("hold_grant", 4'b0100, 2'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 4'b1100, HTRANS_SEQ, 4'b0000);
            step();
            check($sformatf("hold_beat%0d", k), 4'b0100, 2'd2, 1'b0);
        end
        drive(1'b1, 4'b1100, HTRANS_SEQ, 4'b0000);
        step();
        check("hold_expire", 4'b1000, 2'd2, 1'b0);
        drive(1'b1, 4'b1000, HTRANS_SEQ, 4'b0000);
        step();
        check("hold_new_owner", 4'b1000, 2'd3, 1'b0);
        drive(1'b1, 4'b0000, HTRANS_IDLE, 4'b0000);
        step();
        check("hold_park", 4'b0001, 2'd3, 1'b0);

        // Master 0 requests with Hlock while master 1 keeps requesting.
        drive(1'b1, 4'b0001, HTRANS_NONSEQ, 4'b0001);
        step();
        check("lock_grant", 4'b0001, 2'd0, 1'b0);
        for (int i = 1; i <= 22; i++) begin
            drive(1'b1, 4'b0011, HTRANS_SEQ, 4'b0001);
            step();
`ifdef ARB_LOCK_EN
            check($sformatf("lock_beat%0d", i), 4'b0001, 2'd0, 1'b1);
`else
            check($sformatf("nolock_beat%0d", i), (i >= 17) ? 4'b0010 : 4'b0001,
                  (i >= 18) ? 2'd1 : 2'd0, 1'b0);
`endif
        end
`ifdef ARB_LOCK_EN
        drive(1'b0, 4'b0011, HTRANS_SEQ, 4'b0000);
        step();
        check("lock_wait_ready", 4'b0001, 2'd0, 1'b1);
        drive(1'b1, 4'b0011, HTRANS_SEQ, 4'b0000);
        step();
        check("lock_release", 4'b0001, 2'd0, 1'b0);
        drive(1'b1, 4'b0011, HTRANS_SEQ, 4'b0000);
        step();
        check("lock_rearb", 4'b0010, 2'd0, 1'b0);
`endif
        drive(1'b1, 4'b0011, HTRANS_SEQ, 4'b0000);
        step();
        check("pre_reset", 4'b0010, 2'd1, 1'b0);

        // Reset in the middle of a stalled burst.
        drive(1'b0, 4'b0011, HTRANS_SEQ, 4'b0000);
        #3;
        Hreset = 1'b1;
        #1;
        check("reset_async", 4'b0001, 2'd0, 1'b0);
        step();
        check("reset_held", 4'b0001, 2'd0, 1'b0);
        #2;
        Hreset = 1'b0;
        drive(1'b1, 4'b0110, HTRANS_NONSEQ, 4'b0000);
        step();
        check("post_reset_rr", 4'b0010, 2'd0, 1'b0);
        drive(1'b1, 4'b0000, HTRANS_IDLE, 4'b0000);
        step();
        check("post_reset_park", 4'b0001, 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
